updn_cnt_disp: RTL and testbench

- Parametrised up/down counter with multiplexed seven-segment display: DIGITS digits, each in base RADIX (10 = BCD, 16 = hex).
- Count advances on either an internal auto-tick or a debounced manual push-button press, selected by `mode`.
- Supports parallel load and flags full-range wrap-around.
- Drives one-hot digit select `scan` and segment code `dout` for the board's common display header.
- Single clock domain; all rates derived by internal prescalers, no secondary clocks.

---
 rtl/updn_cnt_disp.sv | 209 ++++++++++++++++++++
 tb/tb_updn_cnt_disp.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updn_cnt_disp.sv
// Up/down counter of DIGITS base-RADIX digits, stepped by an auto prescaler or
// a debounced active-low push-button, with a multiplexed seven-segment output.
module updn_cnt_disp #(
  parameter int DIGITS    = 2,
  parameter int RADIX     = 16,
  parameter int AUTO_DIV  = 100000,
  parameter int SCAN_DIV  = 100,
  parameter int DB_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                add,
  input  logic                din,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic [DIGITS-1:0]   scan,
  output logic [7:0]          dout
);

  localparam int AW = $clog2(AUTO_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DB_CYCLES);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0]    DMAX      = 4'(RADIX - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // Segment encoding {dp,g,f,e,d,c,b,a}, decimal point never lit.
  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Button synchroniser and debouncer state
  logic          sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_level_q, db_level_d;
  logic          press;

  // Auto-count prescaler
  logic [AW-1:0] auto_q, auto_d;
  logic          tick;
  logic          step;

  // Counter state
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [4*DIGITS-1:0] digit_next;
  logic [4*DIGITS-1:0] digit_sat;
  logic [DIGITS-1:0]   at_limit;

  // Display scan state
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] scan_q, scan_d;
  logic [7:0]        dout_q, dout_d;
  logic [3:0]        digit_sel;

  // Debouncer: accept a level change only after DB_CYCLES disagreeing samples
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    press      = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
        // Only the released(1) -> pressed(0) transition produces a press.
        press      = db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  // Auto prescaler and step selection; prescaler is parked at 0 in manual mode
  always_comb begin
    tick   = mode & (auto_q == AUTO_LAST);
    auto_d = (!mode || tick) ? '0 : auto_q + AW'(1);
    step   = mode ? tick : press;
  end

  // Per-digit increment/decrement; carry into a digit needs every lower digit at its limit
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] lv;
      logic       cin;

      assign cur = count_q[4*gi +: 4];
      assign lv  = load_val[4*gi +: 4];
      assign at_limit[gi] = add ? (cur == DMAX) : (cur == 4'd0);

      if (gi == 0) begin : g_cin0
        assign cin = step;
      end else begin : g_cinn
        assign cin = step & (&at_limit[gi-1:0]);
      end

      assign digit_sat[4*gi +: 4]  = (lv > DMAX) ? DMAX : lv;
      assign digit_next[4*gi +: 4] = !cin ? cur :
                                     add  ? ((cur == DMAX) ? 4'd0 : cur + 4'd1) :
                                            ((cur == 4'd0) ? DMAX : cur - 4'd1);
    end
  endgenerate

  // Counter next state: load beats step, wrap only on a full-range roll-over
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = digit_sat;
    end else if (step) begin
      count_d = digit_next;
      wrap_d  = &at_limit;
    end
  end

  // Scan sequencing; dout is taken from the registered count so it trails count by one clk
  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    scan_d    = '0;
    digit_sel = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx_d == IW'(d)) begin
        scan_d[d] = 1'b1;
        digit_sel = count_q[4*d +: 4];
      end
    end
    dout_d = seg7(digit_sel);
  end

  // Button path registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_cnt_q   <= '0;
      db_level_q <= 1'b1;
    end else begin
      sync1_q    <= din;
      sync2_q    <= sync1_q;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
    end
  end

  // Prescaler and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_q  <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      auto_q  <= auto_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Display registers; scan and dout always update together
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      scan_q     <= DIGITS'(1);
      dout_q     <= 8'h3F;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      scan_q     <= scan_d;
      dout_q     <= dout_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign scan  = scan_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_updn_cnt_disp.sv
// Bench: one hex and one BCD counter driven with identical stimulus, compared
// against an integer-valued reference model.
module tb_updn_cnt_disp;

  localparam int DIGITS    = 2;
  localparam int AUTO_DIV  = 4;
  localparam int SCAN_DIV  = 3;
  localparam int DB_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       add = 1'b1;
  logic       din = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] count_o [2];
  logic       wrap_o  [2];
  logic [1:0] scan_o  [2];
  logic [7:0] dout_o  [2];

  int checks = 0;
  int errors = 0;
  int RAD [2] = '{16, 10};

  // Reference model state
  int         m_val  [2];
  logic       m_wrap [2];
  logic [7:0] m_dout [2];
  logic [1:0] m_scan = 2'b01;
  int         m_sc = 0, m_idx = 0, m_ph = 0, m_run = 0;
  logic       m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b1;

  always #5 clk = ~clk;

  updn_cnt_disp #(.DIGITS(DIGITS), .RADIX(16), .AUTO_DIV(AUTO_DIV),
                  .SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) u_hex (
    .clk(clk), .rst(rst), .mode(mode), .add(add), .din(din), .load(load),
    .load_val(load_val), .count(count_o[0]), .wrap(wrap_o[0]),
    .scan(scan_o[0]), .dout(dout_o[0]));

  updn_cnt_disp #(.DIGITS(DIGITS), .RADIX(10), .AUTO_DIV(AUTO_DIV),
                  .SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) u_bcd (
    .clk(clk), .rst(rst), .mode(mode), .add(add), .din(din), .load(load),
    .load_val(load_val), .count(count_o[1]), .wrap(wrap_o[1]),
    .scan(scan_o[1]), .dout(dout_o[1]));

  function automatic logic [7:0] seg_of(input int v);
    case (v)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F; 10: return 8'h77; 11: return 8'h7C;
      12: return 8'h39; 13: return 8'h5E; 14: return 8'h79; default: return 8'h71;
    endcase
  endfunction

  // Integer value -> two packed nibbles in base r
  function automatic logic [7:0] nib(input int v, input int r);
    return 8'((((v / r) % r) * 16) + (v % r));
  endfunction

  // Load value -> integer after clamping each nibble to r-1
  function automatic int sat_val(input logic [7:0] lv, input int r);
    int lo, hi;
    lo = int'(lv[3:0]);
    hi = int'(lv[7:4]);
    if (lo > r - 1) lo = r - 1;
    if (hi > r - 1) hi = r - 1;
    return hi * r + lo;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge
  function automatic void model_update();
    logic press, tick, step;
    int nidx, r, dig;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_val[i] = 0; m_wrap[i] = 1'b0; m_dout[i] = 8'h3F;
      end
      m_scan = 2'b01; m_sc = 0; m_idx = 0; m_ph = 0; m_run = 0;
      m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b1;
      return;
    end
    press = 1'b0;
    if (m_s2 != m_lvl) begin
      if (m_run == DB_CYCLES - 1) begin
        press = m_lvl; m_lvl = m_s2; m_run = 0;
      end else begin
        m_run++;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = din;
    tick = mode && (m_ph == AUTO_DIV - 1);
    m_ph = (!mode || tick) ? 0 : m_ph + 1;
    step = mode ? tick : press;
    nidx = m_idx;
    if (m_sc == SCAN_DIV - 1) begin
      m_sc = 0; nidx = (m_idx + 1) % DIGITS;
    end else begin
      m_sc++;
    end
    for (int i = 0; i < 2; i++) begin
      r = RAD[i];
      dig = (nidx == 0) ? (m_val[i] % r) : ((m_val[i] / r) % r);
      m_dout[i] = seg_of(dig);
      m_wrap[i] = 1'b0;
      if (load) begin
        m_val[i] = sat_val(load_val, r);
      end else if (step) begin
        if (add) begin
          if (m_val[i] == r * r - 1) begin m_val[i] = 0; m_wrap[i] = 1'b1; end
          else m_val[i]++;
        end else begin
          if (m_val[i] == 0) begin m_val[i] = r * r - 1; m_wrap[i] = 1'b1; end
          else m_val[i]--;
        end
      end
    end
    m_idx  = nidx;
    m_scan = 2'(1 << nidx);
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_clk();
    tick_clk();
    for (int i = 0; i < 2; i++) begin
      checks++; if (count_o[i] !== 8'h00) begin errors++; $display("FAIL reset_count inst=%0d got=%h exp=00", i, count_o[i]); end
      checks++; if (scan_o[i] !== 2'b01) begin errors++; $display("FAIL reset_scan inst=%0d got=%b exp=01", i, scan_o[i]); end
      checks++; if (dout_o[i] !== 8'h3F) begin errors++; $display("FAIL reset_dout inst=%0d got=%h exp=3f", i, dout_o[i]); end
      checks++; if (wrap_o[i] !== 1'b0) begin errors++; $display("FAIL reset_wrap inst=%0d got=%b exp=0", i, wrap_o[i]); end
    end
    rst = 1'b0;
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      tick_clk();
      for (int i = 0; i < 2; i++) begin
        checks++; if (scan_o[i] !== m_scan) begin errors++; $display("FAIL idle_scan inst=%0d cyc=%0d got=%b exp=%b", i, k, scan_o[i], m_scan); end
        checks++; if (dout_o[i] !== 8'h3F) begin errors++; $display("FAIL idle_dout inst=%0d cyc=%0d got=%h exp=3f", i, k, dout_o[i]); end
      end
    end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_hex_wrap();
    int wraps = 0;
    mode = 1'b1; add = 1'b1; load = 1'b1; load_val = 8'hFE;
    for (int k = 1; k <= 9; k++) begin
      tick_clk();
      load = 1'b0;
      if (wrap_o[0] === 1'b1) wraps++;
      for (int i = 0; i < 2; i++) begin
        checks++; if (count_o[i] !== nib(m_val[i], RAD[i])) begin errors++; $display("FAIL upwrap_count inst=%0d cyc=%0d got=%h exp=%h", i, k, count_o[i], nib(m_val[i], RAD[i])); end
        checks++; if (wrap_o[i] !== m_wrap[i]) begin errors++; $display("FAIL upwrap_wrap inst=%0d cyc=%0d got=%b exp=%b", i, k, wrap_o[i], m_wrap[i]); end
      end
      if (k == 4) begin
        checks++; if (count_o[0] !== 8'hFF) begin errors++; $display("FAIL upwrap_ff got=%h exp=ff", count_o[0]); end
      end
      if (k == 8) begin
        checks++; if (count_o[0] !== 8'h00 || wrap_o[0] !== 1'b1) begin errors++; $display("FAIL upwrap_zero got=%h/%b exp=00/1", count_o[0], wrap_o[0]); end
      end
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL upwrap_pulses got=%0d exp=1", wraps); end
    mode = 1'b0;
    tick_clk();
    $display("test_hex_wrap done checks=%0d", checks);
  endtask

  task automatic test_bcd_borrow();
    mode = 1'b0;
    tick_clk();
    mode = 1'b1; add = 1'b0; load = 1'b1; load_val = 8'h10;
    for (int k = 1; k <= 13; k++) begin
      tick_clk();
      load = 1'b0;
      if (k == 8) begin load = 1'b1; load_val = 8'h00; end
      for (int i = 0; i < 2; i++) begin
        checks++; if (count_o[i] !== nib(m_val[i], RAD[i])) begin errors++; $display("FAIL borrow_count inst=%0d cyc=%0d got=%h exp=%h", i, k, count_o[i], nib(m_val[i], RAD[i])); end
        checks++; if (wrap_o[i] !== m_wrap[i]) begin errors++; $display("FAIL borrow_wrap inst=%0d cyc=%0d got=%b exp=%b", i, k, wrap_o[i], m_wrap[i]); end
      end
      if (k == 4) begin
        checks++; if (count_o[1] !== 8'h09) begin errors++; $display("FAIL borrow_09 got=%h exp=09", count_o[1]); end
        checks++; if (count_o[0] !== 8'h0F) begin errors++; $display("FAIL borrow_0f got=%h exp=0f", count_o[0]); end
      end
      if (k == 8) begin
        checks++; if (count_o[1] !== 8'h08) begin errors++; $display("FAIL borrow_08 got=%h exp=08", count_o[1]); end
      end
      if (k == 12) begin
        checks++; if (count_o[1] !== 8'h99 || wrap_o[1] !== 1'b1) begin errors++; $display("FAIL borrow_99 got=%h/%b exp=99/1", count_o[1], wrap_o[1]); end
        checks++; if (count_o[0] !== 8'hFF || wrap_o[0] !== 1'b1) begin errors++; $display("FAIL borrow_ff got=%h/%b exp=ff/1", count_o[0], wrap_o[0]); end
      end
    end
    mode = 1'b0;
    tick_clk();
    $display("test_bcd_borrow done checks=%0d", checks);
  endtask

  task automatic test_debounce();
    int base [2];
    logic [5:0] bounce = 6'b101101;
    mode = 1'b0; add = 1'b1; din = 1'b1;
    tick_clk();
    for (int i = 0; i < 2; i++) base[i] = m_val[i];
    for (int n = 0; n < 5; n++) begin
      din = 1'b0; repeat (3) tick_clk();
      din = 1'b1; repeat (4) tick_clk();
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (count_o[i] !== nib(base[i], RAD[i])) begin errors++; $display("FAIL glitch_count inst=%0d got=%h exp=%h", i, count_o[i], nib(base[i], RAD[i])); end
    end
    din = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick_clk();
      for (int i = 0; i < 2; i++) begin
        checks++; if (count_o[i] !== nib(m_val[i], RAD[i])) begin errors++; $display("FAIL press_count inst=%0d cyc=%0d got=%h exp=%h", i, k, count_o[i], nib(m_val[i], RAD[i])); end
      end
    end
    for (int k = 0; k < 6; k++) begin
      din = bounce[k];
      tick_clk();
    end
    din = 1'b1;
    repeat (20) tick_clk();
    for (int i = 0; i < 2; i++) begin
      checks++; if (count_o[i] !== nib((base[i] + 1) % (RAD[i] * RAD[i]), RAD[i])) begin errors++; $display("FAIL press_once inst=%0d got=%h exp=%h", i, count_o[i], nib((base[i] + 1) % (RAD[i] * RAD[i]), RAD[i])); end
    end
    $display("test_debounce done checks=%0d", checks);
  endtask

  task automatic test_priority();
    int guard = 0;
    mode = 1'b1; add = 1'b1; load = 1'b0; din = 1'b1;
    while (m_ph != AUTO_DIV - 1 && guard < 2 * AUTO_DIV) begin tick_clk(); guard++; end
    checks++; if (m_ph != AUTO_DIV - 1) begin errors++; $display("FAIL prio_align got=%0d exp=%0d", m_ph, AUTO_DIV - 1); end
    load = 1'b1; load_val = 8'h3C;
    tick_clk();
    checks++; if (count_o[0] !== 8'h3C) begin errors++; $display("FAIL prio_hex got=%h exp=3c", count_o[0]); end
    checks++; if (count_o[1] !== 8'h39) begin errors++; $display("FAIL prio_bcd got=%h exp=39", count_o[1]); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (wrap_o[i] !== 1'b0) begin errors++; $display("FAIL prio_wrap inst=%0d got=%b exp=0", i, wrap_o[i]); end
    end
    load_val = 8'hAB;
    tick_clk();
    load = 1'b0;
    checks++; if (count_o[1] !== 8'h99) begin errors++; $display("FAIL sat_bcd got=%h exp=99", count_o[1]); end
    checks++; if (count_o[0] !== 8'hAB) begin errors++; $display("FAIL sat_hex got=%h exp=ab", count_o[0]); end
    mode = 1'b0;
    tick_clk();
    $display("test_priority done checks=%0d", checks);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic [7:0] exp_c;
    mode = 1'b0; din = 1'b0;
    repeat (2) tick_clk();
    while (m_idx != 1 && guard < 2 * SCAN_DIV * DIGITS) begin tick_clk(); guard++; end
    checks++; if (m_idx != 1) begin errors++; $display("FAIL rstmid_align got=%0d exp=1", m_idx); end
    rst = 1'b1; din = 1'b1; mode = 1'b1; add = 1'b1;
    tick_clk();
    for (int i = 0; i < 2; i++) begin
      checks++; if (scan_o[i] !== 2'b01) begin errors++; $display("FAIL rstmid_scan inst=%0d got=%b exp=01", i, scan_o[i]); end
      checks++; if (dout_o[i] !== 8'h3F) begin errors++; $display("FAIL rstmid_dout inst=%0d got=%h exp=3f", i, dout_o[i]); end
      checks++; if (count_o[i] !== 8'h00 || wrap_o[i] !== 1'b0) begin errors++; $display("FAIL rstmid_count inst=%0d got=%h/%b exp=00/0", i, count_o[i], wrap_o[i]); end
    end
    rst = 1'b0;
    for (int k = 1; k <= AUTO_DIV; k++) begin
      tick_clk();
      exp_c = (k == AUTO_DIV) ? 8'h01 : 8'h00;
      for (int i = 0; i < 2; i++) begin
        checks++; if (count_o[i] !== exp_c) begin errors++; $display("FAIL first_tick inst=%0d cyc=%0d got=%h exp=%h", i, k, count_o[i], exp_c); end
      end
    end
    mode = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick_clk();
      for (int i = 0; i < 2; i++) begin
        checks++; if (count_o[i] !== 8'h01 || wrap_o[i] !== 1'b0) begin errors++; $display("FAIL no_press inst=%0d cyc=%0d got=%h/%b exp=01/0", i, k, count_o[i], wrap_o[i]); end
      end
    end
    $display("test_reset_mid done checks=%0d", checks);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(63) == 0);
      load     = ($urandom_range(11) == 0);
      load_val = 8'($urandom);
      add      = 1'($urandom);
      if ($urandom_range(24) == 0) mode = ~mode;
      if ($urandom_range(9) == 0) din = ~din;
      tick_clk();
      for (int i = 0; i < 2; i++) begin
        checks++; if (count_o[i] !== nib(m_val[i], RAD[i])) begin errors++; $display("FAIL rnd_count inst=%0d cyc=%0d got=%h exp=%h", i, k, count_o[i], nib(m_val[i], RAD[i])); end
        checks++; if (wrap_o[i] !== m_wrap[i]) begin errors++; $display("FAIL rnd_wrap inst=%0d cyc=%0d got=%b exp=%b", i, k, wrap_o[i], m_wrap[i]); end
        checks++; if (scan_o[i] !== m_scan) begin errors++; $display("FAIL rnd_scan inst=%0d cyc=%0d got=%b exp=%b", i, k, scan_o[i], m_scan); end
        checks++; if (dout_o[i] !== m_dout[i]) begin errors++; $display("FAIL rnd_dout inst=%0d cyc=%0d got=%h exp=%h", i, k, dout_o[i], m_dout[i]); end
      end
    end
    rst = 1'b0; load = 1'b0;
    $display("test_random done checks=%0d", checks);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_wrap[i] = 1'b0; m_dout[i] = 8'h3F;
    end
    test_reset();
    test_hex_wrap();
    test_bcd_borrow();
    test_debounce();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
